// File: rtl/seg7_name_decoder.sv
// seg7_name_decoder: decodes sampled 7-segment patterns and tracks the "SEnOLGULGONUL"+blank frame.
// Build option SEG7_DEC_DP_MASK_EN: ignore the dp bit when decoding.
module seg7_name_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       seg_in,
  input  logic             seg_valid,
  input  logic             clr,
  output logic [3:0]       sym_code,
  output logic             sym_valid,
  output logic [3:0]       pos,
  output logic             locked,
  output logic             frame_ok,
  output logic             seq_err,
  output logic [CNT_W-1:0] frame_cnt
);
  typedef enum logic {HUNT, TRACK} state_t;
  localparam logic [3:0] SYM_S = 4'd1;
  localparam logic [3:0] LAST_POS = 4'd13;
  state_t           state_q, state_d;
  logic [3:0]       sym_code_q, sym_code_d;
  logic             sym_valid_q, sym_valid_d;
  logic [3:0]       pos_q, pos_d;
  logic             locked_q, locked_d;
  logic             frame_ok_q, frame_ok_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       seg_m;
  logic [3:0]       dec;
  logic [3:0]       exp_code;
`ifdef SEG7_DEC_DP_MASK_EN
  assign seg_m = {1'b0, seg_in[6:0]};
`else
  assign seg_m = seg_in;
`endif
  always_comb begin
    case (seg_m)
      8'h00:   dec = 4'd0;
      8'h5B:   dec = 4'd1;
      8'h4F:   dec = 4'd2;
      8'h15:   dec = 4'd3;
      8'h7E:   dec = 4'd4;
      8'h0E:   dec = 4'd5;
      8'h5F:   dec = 4'd6;
      8'h3E:   dec = 4'd7;
      default: dec = 4'd15;
    endcase
  end
  always_comb begin
    case (pos_q)
      4'd0:    exp_code = 4'd1;
      4'd1:    exp_code = 4'd2;
      4'd2:    exp_code = 4'd3;
      4'd3:    exp_code = 4'd4;
      4'd4:    exp_code = 4'd5;
      4'd5:    exp_code = 4'd6;
      4'd6:    exp_code = 4'd7;
      4'd7:    exp_code = 4'd5;
      4'd8:    exp_code = 4'd6;
      4'd9:    exp_code = 4'd4;
      4'd10:   exp_code = 4'd3;
      4'd11:   exp_code = 4'd7;
      4'd12:   exp_code = 4'd5;
      default: exp_code = 4'd0;
    endcase
  end
  always_comb begin
    state_d     = state_q;
    sym_code_d  = sym_code_q;
    sym_valid_d = 1'b0;
    pos_d       = pos_q;
    locked_d    = locked_q;
    frame_ok_d  = 1'b0;
    seq_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (seg_valid) begin
      sym_code_d  = dec;
      sym_valid_d = 1'b1;
      if (state_q == HUNT) begin
        if (dec == SYM_S) begin
          pos_d   = 4'd1;
          state_d = TRACK;
        end
      end else if (dec == exp_code) begin
        pos_d      = (pos_q == LAST_POS) ? 4'd0 : pos_q + 4'd1;
        state_d    = (pos_q == LAST_POS) ? HUNT : TRACK;
        frame_ok_d = (pos_q == LAST_POS);
        locked_d   = locked_q | (pos_q == LAST_POS);
        frame_cnt_d = (pos_q != LAST_POS || &frame_cnt_q) ? frame_cnt_q : frame_cnt_q + 1'b1;
      end else begin
        // a stray S is taken as the start of a new frame
        seq_err_d = 1'b1;
        locked_d  = 1'b0;
        pos_d     = (dec == SYM_S) ? 4'd1 : 4'd0;
        state_d   = (dec == SYM_S) ? TRACK : HUNT;
      end
    end
    if (clr) begin
      frame_cnt_d = '0;
      locked_d    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      sym_code_q  <= '0;
      sym_valid_q <= 1'b0;
      pos_q       <= '0;
      locked_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sym_code_q  <= sym_code_d;
      sym_valid_q <= sym_valid_d;
      pos_q       <= pos_d;
      locked_q    <= locked_d;
      frame_ok_q  <= frame_ok_d;
      seq_err_q   <= seq_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign sym_code  = sym_code_q;
  assign sym_valid = sym_valid_q;
  assign pos       = pos_q;
  assign locked    = locked_q;
  assign frame_ok  = frame_ok_q;
  assign seq_err   = seq_err_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_seg7_name_decoder.sv
// tb_seg7_name_decoder: scoreboard bench for seg7_name_decoder; expected tuples are queued per sample and checked on sym_valid.
module tb_seg7_name_decoder;
  localparam int CNT_W = 8;
  typedef struct packed {
    logic [3:0]       code;
    logic [3:0]       pos;
    logic             locked;
    logic             fok;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       seg_in;
  logic             seg_valid;
  logic             clr;
  logic [3:0]       sym_code;
  logic             sym_valid;
  logic [3:0]       pos;
  logic             locked;
  logic             frame_ok;
  logic             seq_err;
  logic [CNT_W-1:0] frame_cnt;
  int               n_vec = 0;
  int               n_err = 0;
  exp_t             sb[$];
  logic [7:0]       frame_pat [14] = '{8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E,
                                       8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E, 8'h00};
  logic [3:0]       frame_code [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                        4'd5, 4'd6, 4'd4, 4'd3, 4'd7, 4'd5, 4'd0};
  logic [3:0]       m_pos = '0;
  logic             m_locked = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  seg7_name_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_valid(seg_valid), .clr(clr),
    .sym_code(sym_code), .sym_valid(sym_valid), .pos(pos), .locked(locked),
    .frame_ok(frame_ok), .seq_err(seq_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] ref_decode(input logic [7:0] p);
    logic [7:0] q;
`ifdef SEG7_DEC_DP_MASK_EN
    q = {1'b0, p[6:0]};
`else
    q = p;
`endif
    for (int i = 0; i < 14; i++) if (frame_pat[i] == q) return frame_code[i];
    return 4'd15;
  endfunction
  task automatic send(input logic [7:0] p, input logic c);
    exp_t e;
    e = '0;
    e.code = ref_decode(p);
    if (m_pos == 0) begin
      if (e.code == 4'd1) m_pos = 4'd1;
    end else if (e.code == frame_code[m_pos]) begin
      if (m_pos == 4'd13) begin
        m_pos = 0;
        e.fok = 1'b1;
        m_locked = 1'b1;
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      end else m_pos = m_pos + 4'd1;
    end else begin
      e.err = 1'b1;
      m_locked = 1'b0;
      m_pos = (e.code == 4'd1) ? 4'd1 : 4'd0;
    end
    if (c) begin
      m_cnt = '0;
      m_locked = 1'b0;
    end
    e.pos = m_pos;
    e.locked = m_locked;
    e.cnt = m_cnt;
    sb.push_back(e);
    seg_in = p;
    seg_valid = 1'b1;
    clr = c;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    clr = 1'b0;
  endtask
  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (sym_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_sym_valid: got sym_code=%0d pos=%0d, expected no output", sym_code, pos);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({sym_code, pos, locked, frame_ok, seq_err, frame_cnt} !== e) begin
            n_err++;
            $display("FAIL sample: got code=%0d pos=%0d lock=%0d fok=%0d err=%0d cnt=%0d, expected code=%0d pos=%0d lock=%0d fok=%0d err=%0d cnt=%0d",
                     sym_code, pos, locked, frame_ok, seq_err, frame_cnt,
                     e.code, e.pos, e.locked, e.fok, e.err, e.cnt);
          end
        end
      end else if (sym_valid === 1'b0 && (frame_ok === 1'b1 || seq_err === 1'b1)) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_pulse: got frame_ok=%0d seq_err=%0d, expected 0 0", frame_ok, seq_err);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    seg_in = '0;
    seg_valid = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {sym_code, sym_valid, pos, locked, frame_ok, seq_err, frame_cnt}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) send(frame_pat[i], 1'b0);
    check("frame1_cnt", frame_cnt, 1);
    check("frame1_locked", locked, 1);
    check("frame1_pos", pos, 0);
    send(8'h5B, 1'b0);
    send(8'h4F, 1'b0);
    send(8'h4F, 1'b0);
    check("mismatch_pos", pos, 0);
    check("mismatch_locked", locked, 0);
    send(8'h5B, 1'b0);
    send(8'h4F, 1'b0);
    send(8'h5B, 1'b0);
    check("resync_pos", pos, 1);
    send(8'h00, 1'b0);
    send(8'hDB, 1'b0);
`ifdef SEG7_DEC_DP_MASK_EN
    check("dp_code", sym_code, 1);
    check("dp_pos", pos, 1);
`else
    check("dp_code", sym_code, 15);
    check("dp_pos", pos, 0);
`endif
    send(8'h00, 1'b0);
    for (int f = 0; f < 257; f++)
      for (int i = 0; i < 14; i++) send(frame_pat[i], 1'b0);
    check("sat_cnt", frame_cnt, 255);
    for (int i = 0; i < 13; i++) send(frame_pat[i], 1'b0);
    send(frame_pat[13], 1'b1);
    check("clr_fok", frame_ok, 1);
    check("clr_cnt", frame_cnt, 0);
    check("clr_locked", locked, 0);
    for (int i = 0; i < 14; i++) send(frame_pat[i], 1'b0);
    for (int i = 0; i < 7; i++) send(frame_pat[i], 1'b0);
    check("pre_reset_pos", pos, 7);
    seg_in = 8'h0E;
    seg_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seg_valid = 1'b0;
    m_pos = '0;
    m_locked = 1'b0;
    m_cnt = '0;
    check("midframe_reset", {sym_code, sym_valid, pos, locked, frame_ok, seq_err, frame_cnt}, 0);
    send(8'h5B, 1'b0);
    check("post_reset_pos", pos, 1);
    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
